// File: rtl/mem_arbiter_if.sv
// Requester-side and register-bank-side signal bundle for mem_arbiter.
// master = requesters + register bank (environment), slave = the arbiter.
interface mem_arbiter_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned AW     = 4,
    parameter int unsigned DW     = 8
);
    logic [NUM_CH-1:0]    ch_req;
    logic [NUM_CH-1:0]    ch_we;
    logic [NUM_CH*AW-1:0] ch_addr;
    logic [NUM_CH*DW-1:0] ch_wdata;
    logic [NUM_CH-1:0]    ch_gnt;
    logic [NUM_CH-1:0]    ch_rvalid;
    logic [DW-1:0]        ch_rdata;
    logic [AW-1:0]        reg_addr;
    logic [DW-1:0]        reg_wdata;
    logic                 reg_write_en;
    logic                 reg_read_en;
    logic [DW-1:0]        reg_rdata;

    modport master (
        output ch_req, ch_we, ch_addr, ch_wdata, reg_rdata,
        input  ch_gnt, ch_rvalid, ch_rdata, reg_addr, reg_wdata, reg_write_en, reg_read_en
    );

    modport slave (
        input  ch_req, ch_we, ch_addr, ch_wdata, reg_rdata,
        output ch_gnt, ch_rvalid, ch_rdata, reg_addr, reg_wdata, reg_write_en, reg_read_en
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-cycle register-bank arbiter for NUM_CH requesters, one transaction per cycle.
// Define MEM_ARBITER_RR_EN for round-robin arbitration; default is fixed lowest-index priority.
module mem_arbiter #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned AW     = 4,
    parameter int unsigned DW     = 8
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam int unsigned PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              found;
    logic [PW-1:0]     win;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic [NUM_CH-1:0] rvalid_q;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              re_q, re_d;

`ifdef MEM_ARBITER_RR_EN
    logic [PW-1:0] ptr_q, ptr_d;
    int unsigned   idx;

    // Search upward from the pointer with wrap; pointer moves past each winner.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = (32'(ptr_q) + i) % NUM_CH;
            if (!found && bus.ch_req[PW'(idx)]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (32'(win) == NUM_CH - 1) ? '0 : PW'(32'(win) + 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Lowest-index requester wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!found && bus.ch_req[PW'(i)]) begin
                found = 1'b1;
                win   = PW'(i);
            end
        end
    end
`endif

    // Next transaction; address and write data hold on idle cycles.
    always_comb begin
        gnt_d   = '0;
        we_d    = 1'b0;
        re_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (found) begin
            gnt_d[win] = 1'b1;
            we_d       = bus.ch_we[win];
            re_d       = !bus.ch_we[win];
            addr_d     = bus.ch_addr[32'(win)*AW +: AW];
            wdata_d    = bus.ch_we[win] ? bus.ch_wdata[32'(win)*DW +: DW] : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q    <= '0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rvalid_q <= '0;
        end else begin
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            re_q     <= re_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rvalid_q <= re_q ? gnt_q : '0;
        end
    end

    assign bus.ch_gnt       = gnt_q;
    assign bus.ch_rvalid    = rvalid_q;
    assign bus.ch_rdata     = bus.reg_rdata;
    assign bus.reg_addr     = addr_q;
    assign bus.reg_wdata    = wdata_q;
    assign bus.reg_write_en = we_q;
    assign bus.reg_read_en  = re_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic against a
// transaction-level model (4 channels with MEM_ARBITER_RR_EN, else 2).
module tb_mem_arbiter;
`ifdef MEM_ARBITER_RR_EN
    localparam int NCH = 4;
`else
    localparam int NCH = 2;
`endif
    localparam int AW = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    mem_arbiter_if #(.NUM_CH(NCH), .AW(AW), .DW(DW)) bus ();
    mem_arbiter #(.NUM_CH(NCH), .AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Register bank environment: read data valid the cycle after the read strobe.
    logic [DW-1:0] bank [16] = '{5: 8'h12, default: 8'h00};
    always @(posedge clk) begin
        if (bus.reg_write_en) bank[bus.reg_addr] <= bus.reg_wdata;
        if (bus.reg_read_en)  bus.reg_rdata <= bank[bus.reg_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ch, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.ch_req[ch]              = 1'b1;
        bus.ch_we[ch]               = we;
        bus.ch_addr[ch*AW +: AW]    = a;
        bus.ch_wdata[ch*DW +: DW]   = d;
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0]     exm [16] = '{5: 8'h12, default: 8'h00};
    logic              rst_edge = 1'b1;
    logic [NCH-1:0]    s_req = '0;
    logic [NCH-1:0]    s_we = '0;
    logic [NCH*AW-1:0] s_addr = '0;
    logic [NCH*DW-1:0] s_wdata = '0;
    int                ptr = 0;
    logic [AW-1:0]     m_addr = '0;
    logic [DW-1:0]     m_wdata = '0;
    bit                pend = 1'b0;
    int                pend_ch = 0;
    logic [DW-1:0]     pend_data = '0;

    always @(posedge clk) rst_edge = rst;

    function automatic int pick(input logic [NCH-1:0] req, input int p);
`ifdef MEM_ARBITER_RR_EN
        for (int k = 0; k < NCH; k++) if (req[(p + k) % NCH]) return (p + k) % NCH;
`else
        for (int k = 0; k < NCH; k++) if (req[k]) return k;
`endif
        return -1;
    endfunction

    // Each negedge: derive what the last edge must have produced, compare, then sample inputs.
    initial begin
        int             w;
        logic [NCH-1:0] e_gnt, e_rvalid;
        logic           e_we, e_re;
        logic [DW-1:0]  e_rdata;
        forever begin
            @(negedge clk);
            e_gnt = '0; e_rvalid = '0; e_we = 1'b0; e_re = 1'b0; e_rdata = '0;
            if (rst || rst_edge) begin
                ptr = 0; m_addr = '0; m_wdata = '0; pend = 1'b0;
            end else begin
                if (pend) begin
                    e_rvalid[pend_ch] = 1'b1;
                    e_rdata = pend_data;
                end
                pend = 1'b0;
                w = pick(s_req, ptr);
                if (w >= 0) begin
                    e_gnt[w] = 1'b1;
                    m_addr = s_addr[w*AW +: AW];
                    if (s_we[w]) begin
                        e_we = 1'b1;
                        m_wdata = s_wdata[w*DW +: DW];
                        exm[m_addr] = m_wdata;
                    end else begin
                        e_re = 1'b1;
                        m_wdata = '0;
                        pend = 1'b1;
                        pend_ch = w;
                        pend_data = exm[m_addr];
                    end
                    ptr = (w + 1) % NCH;
                end
            end
            check("gnt",      64'(bus.ch_gnt),       64'(e_gnt));
            check("write_en", 64'(bus.reg_write_en), 64'(e_we));
            check("read_en",  64'(bus.reg_read_en),  64'(e_re));
            check("reg_addr", 64'(bus.reg_addr),     64'(m_addr));
            check("reg_wdata",64'(bus.reg_wdata),    64'(m_wdata));
            check("rvalid",   64'(bus.ch_rvalid),    64'(e_rvalid));
            if (e_rvalid != '0) check("rdata", 64'(bus.ch_rdata), 64'(e_rdata));
            s_req = bus.ch_req; s_we = bus.ch_we; s_addr = bus.ch_addr; s_wdata = bus.ch_wdata;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int order [5] = '{0, 1, 2, 3, 0};
        bus.ch_req = '0; bus.ch_we = '0; bus.ch_addr = '0; bus.ch_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt",    64'(bus.ch_gnt),       64'd0);
        check("rst_we",     64'(bus.reg_write_en), 64'd0);
        check("rst_addr",   64'(bus.reg_addr),     64'd0);
        check("rst_rvalid", 64'(bus.ch_rvalid),    64'd0);
        rst = 1'b0;

        // ch1 write addr 3 data 59
        drive(1, 1'b1, 4'd3, 8'h59);
        step();
        check("wr_gnt",   64'(bus.ch_gnt),       64'd2);
        check("wr_we",    64'(bus.reg_write_en), 64'd1);
        check("wr_re",    64'(bus.reg_read_en),  64'd0);
        check("wr_addr",  64'(bus.reg_addr),     64'd3);
        check("wr_wdata", 64'(bus.reg_wdata),    64'h59);
        bus.ch_req[1] = 1'b0;

        // ch0 read addr 5 returns 12
        drive(0, 1'b0, 4'd5, 8'hEE);
        step();
        check("rd_gnt",   64'(bus.ch_gnt),      64'd1);
        check("rd_re",    64'(bus.reg_read_en), 64'd1);
        check("rd_wdata", 64'(bus.reg_wdata),   64'd0);
        bus.ch_req[0] = 1'b0;
        step();
        check("rd_rvalid", 64'(bus.ch_rvalid), 64'd1);
        check("rd_rdata",  64'(bus.ch_rdata),  64'h12);

        // ch0 and ch1 together
        drive(0, 1'b0, 4'd2, 8'h00);
        drive(1, 1'b1, 4'd4, 8'hA5);
        step();
`ifdef MEM_ARBITER_RR_EN
        check("pair_first", 64'(bus.ch_gnt), 64'd2);
`else
        check("pair_first", 64'(bus.ch_gnt), 64'd1);
`endif
        bus.ch_req = bus.ch_req & ~bus.ch_gnt;
        step();
`ifdef MEM_ARBITER_RR_EN
        check("pair_second", 64'(bus.ch_gnt), 64'd1);
`else
        check("pair_second", 64'(bus.ch_gnt), 64'd2);
`endif
        check("pair_excl", 64'(bus.reg_write_en & bus.reg_read_en), 64'd0);
        bus.ch_req = bus.ch_req & ~bus.ch_gnt;
        repeat (2) step();

        // reset in the cycle of a read grant drops its rvalid
        drive(0, 1'b0, 4'd5, 8'h00);
        step();
        check("rr_gnt", 64'(bus.ch_gnt), 64'd1);
        rst = 1'b1;
        bus.ch_req[0] = 1'b0;
        #1;
        check("async_gnt",  64'(bus.ch_gnt),      64'd0);
        check("async_re",   64'(bus.reg_read_en), 64'd0);
        check("async_addr", 64'(bus.reg_addr),    64'd0);
        step();
        check("async_rvalid", 64'(bus.ch_rvalid), 64'd0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_gnt", 64'(bus.ch_gnt), 64'd0);

`ifdef MEM_ARBITER_RR_EN
        // all channels request continuously
        for (int i = 0; i < NCH; i++) drive(i, 1'b1, AW'(i + 8), DW'(i));
        for (int k = 0; k < 5; k++) begin
            step();
            check("rr_order", 64'(bus.ch_gnt), 64'(1 << order[k]));
        end
        bus.ch_req = '0;
        step();
`endif

        // write addr 7 then idle: address holds
        drive(0, 1'b1, 4'd7, 8'h3C);
        step();
        check("w7_addr", 64'(bus.reg_addr), 64'd7);
        bus.ch_req[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check("idle_we",   64'(bus.reg_write_en), 64'd0);
            check("idle_addr", 64'(bus.reg_addr),     64'd7);
        end

        // random traffic with occasional reset pulses
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NCH; i++) begin
                if (!bus.ch_req[i] || bus.ch_gnt[i]) begin
                    if ($urandom_range(0, 99) < 45)
                        drive(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
                    else
                        bus.ch_req[i] = 1'b0;
                end
            end
            if (!rst && $urandom_range(0, 299) == 0) rst = 1'b1;
            else if (rst) rst = 1'b0;
            step();
        end
        bus.ch_req = '0;
        rst = 1'b0;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
